// File: rtl/map_frame_serializer.sv
// map_frame_serializer: captures a one-cycle hit-map frame and streams it as 16-bit words
// Ports: clk, rst_n (async, active-low); array_header + array_in00..37 frame input, sampled
// when array_header[37]=1 and idle; tx_data/tx_valid/tx_ready word handshake with tx_sof on H0
// and tx_eof on T1; busy while a frame is held; drop_cnt saturating count of frames lost while busy.
// Build option: define MAP_ZS_EN to skip all-zero rows (zero-suppression).
module map_frame_serializer #(
    parameter int DROP_CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [37:0]           array_header,
    input  logic [37:0]           array_in00, array_in01, array_in02, array_in03, array_in04,
    input  logic [37:0]           array_in05, array_in06, array_in07, array_in08, array_in09,
    input  logic [37:0]           array_in10, array_in11, array_in12, array_in13, array_in14,
    input  logic [37:0]           array_in15, array_in16, array_in17, array_in18, array_in19,
    input  logic [37:0]           array_in20, array_in21, array_in22, array_in23, array_in24,
    input  logic [37:0]           array_in25, array_in26, array_in27, array_in28, array_in29,
    input  logic [37:0]           array_in30, array_in31, array_in32, array_in33, array_in34,
    input  logic [37:0]           array_in35, array_in36, array_in37,
    output logic [15:0]           tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  tx_sof,
    output logic                  tx_eof,
    output logic                  busy,
    output logic [DROP_CNT_W-1:0] drop_cnt
);
    typedef enum logic [1:0] {IDLE, HDR, ROW, TRL} state_t;
    state_t      state, ns;
    logic [1:0]  sub, nsub;
    logic [5:0]  r, nr, pick, nrows;
    logic [37:0] mask, mask_init;
    logic [36:16] hdr;
    logic [37:0] rows_in [38];
    logic [37:0] shadow [38];
    logic [15:0] csum, nword;
    logic        cap, hs, enter_row;
    assign rows_in = '{array_in00, array_in01, array_in02, array_in03, array_in04, array_in05,
                       array_in06, array_in07, array_in08, array_in09, array_in10, array_in11,
                       array_in12, array_in13, array_in14, array_in15, array_in16, array_in17,
                       array_in18, array_in19, array_in20, array_in21, array_in22, array_in23,
                       array_in24, array_in25, array_in26, array_in27, array_in28, array_in29,
                       array_in30, array_in31, array_in32, array_in33, array_in34, array_in35,
                       array_in36, array_in37};
    assign busy      = state != IDLE;
    assign tx_valid  = busy;
    assign cap       = array_header[37] && !busy;
    assign hs        = tx_valid && tx_ready;
    assign enter_row = hs && ns == ROW && nsub == 2'd0;
    // mask holds rows still to be sent; the lowest set bit is the next row, so the
    // same walk serves both the full frame (all ones) and the zero-suppressed one
    always_comb begin
        mask_init = '1;
        pick = '0;
        for (int i = 37; i >= 0; i--) begin
`ifdef MAP_ZS_EN
            mask_init[i] = |rows_in[i];
`endif
            pick = mask[i] ? 6'(i) : pick;
        end
        ns   = state;
        nsub = sub;
        nr   = r;
        if (cap) begin
            ns   = HDR;
            nsub = 2'd0;
        end else if (hs) begin
            if (state == TRL ? sub == 2'd0 : sub != 2'd2) nsub = sub + 2'd1;
            else if (state == TRL) ns = IDLE;
            else if (|mask) begin
                ns   = ROW;
                nsub = 2'd0;
                nr   = pick;
            end else begin
                ns   = TRL;
                nsub = 2'd0;
            end
        end
        // word for the position being entered; H0 comes straight from the strobe header
        // and T1 folds in the T0 word currently on the bus
        case (ns)
            HDR:     nword = nsub == 2'd0 ? array_header[15:0] :
                             nsub == 2'd1 ? {6'b0, hdr[25:16]} : {5'b0, hdr[36:26]};
            ROW:     nword = nsub == 2'd0 ? {2'b01, nr, shadow[nr][37:30]} :
                             nsub == 2'd1 ? shadow[nr][29:14] : {shadow[nr][13:0], 2'b00};
            TRL:     nword = nsub == 2'd0 ? {2'b11, 8'h00, nrows} : csum ^ tx_data;
            default: nword = '0;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            sub      <= '0;
            r        <= '0;
            mask     <= '0;
            nrows    <= '0;
            csum     <= '0;
            tx_data  <= '0;
            tx_sof   <= 1'b0;
            tx_eof   <= 1'b0;
            drop_cnt <= '0;
        end else begin
            state <= ns;
            sub   <= nsub;
            r     <= nr;
            if (cap) begin
                mask  <= mask_init;
                nrows <= '0;
                csum  <= '0;
            end else if (hs) csum <= csum ^ tx_data;
            if (enter_row) begin
                mask[nr] <= 1'b0;
                nrows    <= nrows + 6'd1;
            end
            if (cap || hs) begin
                tx_data <= nword;
                tx_sof  <= cap;
                tx_eof  <= ns == TRL && nsub == 2'd1;
            end
            if (array_header[37] && busy && !(&drop_cnt)) drop_cnt <= drop_cnt + DROP_CNT_W'(1);
        end
    end
    always_ff @(posedge clk) begin
        if (cap) begin
            hdr    <= array_header[36:16];
            shadow <= rows_in;
        end
    end
endmodule

// File: tb/tb_map_frame_serializer.sv
// tb_map_frame_serializer: randomized and directed checks of map_frame_serializer against a word-list model
module tb_map_frame_serializer;
`ifdef MAP_ZS_EN
    localparam bit ZS = 1'b1;
`else
    localparam bit ZS = 1'b0;
`endif
    localparam int NW  = ZS ? 11 : 119;
    localparam int R7  = ZS ? 3 : 24;
    localparam int T0I = ZS ? 9 : 117;
    localparam int ZT0 = ZS ? 3 : 117;
    logic        clk = 1'b0, rst_n = 1'b0, tx_ready = 1'b0;
    logic        tx_valid, tx_sof, tx_eof, busy;
    logic [15:0] tx_data;
    logic [7:0]  drop_cnt;
    logic [37:0] hdr_in = '0;
    logic [37:0] rin [38] = '{default: '0};
    logic [37:0] hdr_v;
    logic [37:0] rows_v [38];
    logic [15:0] exp_w [$];
    logic [17:0] got [$];
    logic        pv = 1'b0, pr = 1'b0;
    logic [17:0] pd = '0;
    int          n_cmp = 0, n_bad = 0, mode = 0, ph = 0;

    map_frame_serializer dut (
        .clk(clk), .rst_n(rst_n), .array_header(hdr_in),
        .array_in00(rin[0]),  .array_in01(rin[1]),  .array_in02(rin[2]),  .array_in03(rin[3]),
        .array_in04(rin[4]),  .array_in05(rin[5]),  .array_in06(rin[6]),  .array_in07(rin[7]),
        .array_in08(rin[8]),  .array_in09(rin[9]),  .array_in10(rin[10]), .array_in11(rin[11]),
        .array_in12(rin[12]), .array_in13(rin[13]), .array_in14(rin[14]), .array_in15(rin[15]),
        .array_in16(rin[16]), .array_in17(rin[17]), .array_in18(rin[18]), .array_in19(rin[19]),
        .array_in20(rin[20]), .array_in21(rin[21]), .array_in22(rin[22]), .array_in23(rin[23]),
        .array_in24(rin[24]), .array_in25(rin[25]), .array_in26(rin[26]), .array_in27(rin[27]),
        .array_in28(rin[28]), .array_in29(rin[29]), .array_in30(rin[30]), .array_in31(rin[31]),
        .array_in32(rin[32]), .array_in33(rin[33]), .array_in34(rin[34]), .array_in35(rin[35]),
        .array_in36(rin[36]), .array_in37(rin[37]),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_sof(tx_sof),
        .tx_eof(tx_eof), .busy(busy), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(string tag, logic [31:0] a, logic [31:0] e);
        n_cmp++;
        assert (a === e) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, a, e);
        end
    endtask

    // ready pattern: 0 always, 1 one cycle in three, 2 random, 3 never
    initial forever begin
        @(posedge clk);
        #1;
        ph = (ph + 1) % 3;
        tx_ready = mode == 0 ? 1'b1 : mode == 1 ? (ph == 0) : mode == 2 ? 1'($urandom) : 1'b0;
    end

    // collect accepted words; a stalled word must stay valid and unchanged
    always @(negedge clk) begin
        if (!rst_n) pv = 1'b0;
        else begin
            if (pv && !pr) chk("stall", {13'b0, tx_valid, tx_sof, tx_eof, tx_data}, {14'b1, pd});
            if (tx_valid && tx_ready) got.push_back({tx_sof, tx_eof, tx_data});
            pv = tx_valid;
            pr = tx_ready;
            pd = {tx_sof, tx_eof, tx_data};
        end
    end

    // expected frame as a plain list of words built from hdr_v / rows_v
    task automatic build();
        int n = 0;
        logic [15:0] x = '0;
        exp_w.delete();
        exp_w.push_back(hdr_v[15:0]);
        exp_w.push_back({6'b0, hdr_v[25:16]});
        exp_w.push_back({5'b0, hdr_v[36:26]});
        for (int i = 0; i < 38; i++)
            if (!ZS || rows_v[i] != 0) begin
                exp_w.push_back({2'b01, 6'(i), rows_v[i][37:30]});
                exp_w.push_back(rows_v[i][29:14]);
                exp_w.push_back({rows_v[i][13:0], 2'b00});
                n++;
            end
        exp_w.push_back({2'b11, 8'h00, 6'(n)});
        foreach (exp_w[i]) x ^= exp_w[i];
        exp_w.push_back(x);
    endtask

    task automatic rand_frame(int zp);
        hdr_v = {1'b1, 11'($urandom), 10'($urandom), 16'hAAAA};
        foreach (rows_v[i]) rows_v[i] = $urandom_range(99) < zp ? 38'd0 : {6'($urandom), 32'($urandom)};
    endtask

    task automatic send();
        @(posedge clk);
        #1;
        got.delete();
        build();
        hdr_in = hdr_v;
        rin = rows_v;
        @(posedge clk);
        #1;
        chk("h0_latency", {14'b0, tx_valid, tx_sof, tx_data}, {14'b0, 2'b11, hdr_v[15:0]});
        hdr_in[37] = 1'b0;
        foreach (rin[i]) rin[i] = {6'($urandom), 32'($urandom)};
    endtask

    task automatic check_frame(string tag);
        int k = 0;
        while (got.size() < exp_w.size() && k < 3000) begin
            @(negedge clk);
            k++;
        end
        repeat (4) @(negedge clk);
        chk({tag, "_len"}, got.size(), exp_w.size());
        for (int i = 0; i < exp_w.size() && i < got.size(); i++)
            chk($sformatf("%s_w%0d", tag, i), {14'b0, got[i]},
                {14'b0, i == 0, i == exp_w.size() - 1, exp_w[i]});
        chk({tag, "_idle"}, {30'b0, busy, tx_valid}, 0);
    endtask

    initial begin
        int k;
        #3;
        chk("rst_out", {11'b0, tx_data, tx_valid, tx_sof, tx_eof, busy}, 0);
        chk("rst_drop", {24'b0, drop_cnt}, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_no_strobe", {30'b0, tx_valid, busy}, 0);

        hdr_v = {1'b1, 11'h080, 10'h007, 16'hAAAA};
        foreach (rows_v[i]) rows_v[i] = '0;
        rows_v[7] = 38'h20;
        rows_v[16] = 38'h1;
        send();
        check_frame("dir");
        chk("dir_count", got.size(), NW);
        chk("dir_h0", {14'b0, got[0]}, {14'b0, 2'b10, 16'hAAAA});
        chk("dir_h1", {16'b0, got[1][15:0]}, 32'h0007);
        chk("dir_h2", {16'b0, got[2][15:0]}, 32'h0080);
        chk("dir_r7", {got[R7][15:0], got[R7 + 1][15:0]}, 32'h4700_0000);
        chk("dir_r7b", {16'b0, got[R7 + 2][15:0]}, 32'h0080);
        chk("dir_t0", {16'b0, got[T0I][15:0]}, ZS ? 32'hC002 : 32'hC026);

        foreach (rows_v[i]) rows_v[i] = '0;
        send();
        check_frame("zero");
        chk("zero_count", got.size(), ZS ? 5 : 119);
        chk("zero_t0", {16'b0, got[ZT0][15:0]}, ZS ? 32'hC000 : 32'hC026);

        for (int f = 0; f < 3; f++) begin
            rand_frame(f * 45);
            send();
            check_frame($sformatf("rnd%0d", f));
        end

        mode = 1;
        rand_frame(30);
        send();
        check_frame("bp3");
        mode = 2;
        rand_frame(60);
        send();
        check_frame("bprnd");
        mode = 0;

        rand_frame(0);
        send();
        repeat (8) @(posedge clk);
        #1 hdr_in = {1'b1, 37'($urandom)};
        @(posedge clk);
        #1 hdr_in[37] = 1'b0;
        k = 0;
        while (!(tx_valid && tx_eof) && k < 500) begin
            @(negedge clk);
            k++;
        end
        hdr_in[37] = 1'b1;
        @(posedge clk);
        #1 hdr_in[37] = 1'b0;
        chk("drop2", {24'b0, drop_cnt}, 2);
        check_frame("ovf");

        mode = 3;
        rand_frame(0);
        send();
        hdr_in[37] = 1'b1;
        repeat (300) @(posedge clk);
        #1 hdr_in[37] = 1'b0;
        chk("drop_sat", {24'b0, drop_cnt}, 255);
        mode = 0;
        check_frame("sat");
        chk("drop_hold", {24'b0, drop_cnt}, 255);

        rand_frame(0);
        send();
        k = 0;
        while (got.size() < 50 && k < 500) begin
            @(negedge clk);
            k++;
        end
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst", {3'b0, tx_data, tx_valid, tx_sof, tx_eof, busy, drop_cnt}, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        rand_frame(20);
        send();
        check_frame("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
